// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package seq_mult_pkg;

    // Controller states: waiting, iterating partial products, result pulse.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_add_stage.sv
// N-bit adder with carry-out feeding the product-high register.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module mult_add_stage #(
    parameter int N = 8
) (
    input  logic [N-1:0] hi,
    input  logic [N-1:0] addend,
    output logic [N-1:0] sum,
    output logic         c
);

    // Carry-in is always zero; the carry-out becomes the new top bit of Hi.
    assign {c, sum} = {1'b0, hi} + {1'b0, addend};

endmodule

// File: rtl/seq_mult.sv
// Unsigned N x N -> 2N shift-and-add multiplier, one partial product per clock.
// Latency: accepting edge is cycle 0, N RUN cycles, Done pulses in cycle N+1.
// Backpressure: Start is honoured only while Ready=1 (IDLE or DONE); ignored in RUN.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           Ready,
    output logic           Done,
    output logic [2*N-1:0] P
);

    localparam int CW = $clog2(N + 1);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  areg;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [CW-1:0] cnt;
    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          c;
    logic          load;
    logic          step;
    logic          last;

    // The multiplicand is added only when the current multiplier bit is set.
    assign addend = lo[0] ? areg : '0;
    assign last   = (cnt == CW'(1));

    mult_add_stage #(
        .N(N)
    ) u_add (
        .hi    (hi),
        .addend(addend),
        .sum   (sum),
        .c     (c)
    );

    // State register; reset forces IDLE immediately, killing any operation.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs. RUN never looks at Start, so an
    // unknown Start while busy cannot disturb the operation.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        Ready     = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                Ready = 1'b1;
                if (Start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Ready = 1'b1;
                Done  = 1'b1;
                if (Start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iteration and result register. P only
    // changes on the final iteration so the previous product stays visible
    // throughout RUN.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            areg <= '0;
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            P    <= '0;
        end else if (load) begin
            areg <= A;
            lo   <= B;
            hi   <= '0;
            cnt  <= CW'(N);
        end else if (step) begin
            hi  <= {c, sum[N-1:1]};
            lo  <= {sum[0], lo[N-1:1]};
            cnt <= cnt - CW'(1);
            if (last) begin
                P <= {c, sum, lo[N-1:1]};
            end
        end
    end

endmodule
